stream_in_buf: RTL and testbench
================================

// Module: stream_in_buf
// PURPOSE
//  Ping-pong input buffer between the S_AXIS character stream and the train/forward core.
//  - Deserializes BATCH_SIZE*N characters of CHAR_LEN bits into one batch bank.
//  - Presents a full bank to the core as a flat parallel word.
//  - Bank B fills while the core consumes bank A, so the host can send batch l+1 during run l.
// PARAMETERS
//  CHAR_LEN    8   bits per stream character (=`CHAR_LEN)
//  N           10  characters per sample (=`N)
//  BATCH_SIZE  4   samples per batch (=`BATCH_SIZE)
//  DEPTH = BATCH_SIZE*N (localparam); beats per batch; counter width $clog2(DEPTH)
// PORTS
//  clk            in   1                     system clock (ACLK domain)
//  rst            in   1                     synchronous, active-high reset
//  s_axis_tdata   in   CHAR_LEN              input character
//  s_axis_tvalid  in   1                     input beat valid
//  s_axis_tlast   in   1                     last beat of batch
//  s_axis_tready  out  1                     buffer can accept beat
//  next           in   1                     1-cycle pulse: core done with current bank
//  q_valid        out  1                     q_data holds a complete batch
//  q_data         out  DEPTH*CHAR_LEN        batch; beat k at [k*CHAR_LEN +: CHAR_LEN]
//  err            out  1                     sticky framing error (see CONFIGURATION)
// BEHAVIOUR
//  - Reset outputs: s_axis_tready=1, q_valid=0, q_data=0, err=0.
//  - Reset state: both banks empty and zeroed, wr_bank=0, rd_bank=0, wr_cnt=0.
//  - Reset mid-fill or mid-use discards all data; no partial batch survives.
//  - Per-bank state: EMPTY -> FILLING (first accepted beat) -> FULL (last beat accepted).
//  - FULL -> EMPTY on next while the bank is rd_bank. An empty bank is zeroed on entry to EMPTY.
//  - Beat accepted when s_axis_tvalid & s_axis_tready; written to bank[wr_bank][wr_cnt]; wr_cnt++.
//  - s_axis_tready = (bank[wr_bank] != FULL). Registered; deasserts the cycle after a bank fills
//    if the other bank is also FULL.
//  - Batch end is detected at wr_cnt==DEPTH-1 on an accepted beat. At that point:
//    bank goes FULL, wr_cnt wraps to 0, wr_bank toggles.
//  - q_valid = (bank[rd_bank]==FULL), registered.
//    Latency: last beat accepted at cycle t -> q_valid=1 at t+1 when rd_bank is that bank.
//  - q_data is a registered copy of bank[rd_bank]. It is stable while q_valid=1 and zero when empty.
//  - next with q_valid=1: rd_bank frees, rd_bank toggles.
//    q_valid at t+1 = fullness of the other bank.
//  - next with q_valid=0 is ignored.
//  - next and the last beat of the other bank in the same cycle: both take effect.
//    The freed bank becomes wr target only after wr_bank toggles onto it.
//    q_valid stays 1 at t+1 and q_data switches to the new batch.
//  - Both banks FULL: tready=0 until next. Beats are never dropped or overwritten.
//  - No combinational path from next to s_axis_tready or q_valid.
// CONFIGURATION
//  Macro STREAM_IN_ERR_EN. Defined:
//   - TLAST is checked.
//   - TLAST with wr_cnt<DEPTH-1 closes the bank early. Unwritten entries stay 0, err<=1.
//   - wr_cnt==DEPTH-1 without TLAST: the bank still closes, err<=1.
//   - err clears only on rst.
//  Not defined:
//   - s_axis_tlast is ignored; batch length is count-only.
//   - err is tied 0.
// TESTING
//  1 rst, stream beats 0..DEPTH-1 (data=k) with TLAST on the last beat
//    -> q_valid=1 the cycle after the last beat; q_data beat k==k; err=0.
//  2 Fill bank0, then stream a second batch (data=k+100) without next
//    -> the second batch is accepted, tready=0 afterwards.
//    next -> q_data beat0==100 the next cycle, tready=1.
//  3 Both banks full, hold tvalid=1 for 20 cycles -> no beat accepted, q_data unchanged.
//    next -> exactly one bank frees.
//  4 next pulse on the same cycle as the last beat of bank1
//    -> q_valid stays 1, q_data switches to bank1, tready=1.
//  5 STREAM_IN_ERR_EN: TLAST at beat 5 of 40 -> q_valid=1, beats 6..39==0, err=1.
//    Without the macro, the same stimulus leaves the bank FILLING and err=0.
//  6 rst asserted after 17 beats -> q_valid=0, tready=1.
//    A full batch then streams correctly from beat 0.

Source files
------------

// File: rtl/stream_in_buf_if.sv
// Handshake bundle for stream_in_buf: S_AXIS character stream in, parallel batch out.
interface stream_in_buf_if #(
  parameter int CHAR_LEN = 8,
  parameter int DEPTH    = 40
);
  logic [CHAR_LEN-1:0]       s_axis_tdata;
  logic                      s_axis_tvalid;
  logic                      s_axis_tlast;
  logic                      s_axis_tready;
  logic                      next;
  logic                      q_valid;
  logic [DEPTH*CHAR_LEN-1:0] q_data;
  logic                      err;

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, next,
    input  s_axis_tready, q_valid, q_data, err
  );

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, next,
    output s_axis_tready, q_valid, q_data, err
  );
endinterface

// File: rtl/stream_in_buf.sv
// Ping-pong batch buffer: one bank fills from S_AXIS while the core reads the other.
// Optional TLAST framing check enabled by defining STREAM_IN_ERR_EN.
module stream_in_buf #(
  parameter int CHAR_LEN   = 8,
  parameter int N          = 10,
  parameter int BATCH_SIZE = 4
) (
  input  logic            clk,
  input  logic            rst,
  stream_in_buf_if.slave  bus
);
  localparam int DEPTH = BATCH_SIZE * N;
  localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_t;

  logic [CHAR_LEN-1:0]       bank_r [2][DEPTH];
  bank_state_t               state_r [2];
  logic                      wr_bank_r;
  logic                      rd_bank_r;
  logic [CNT_W-1:0]          wr_cnt_r;
  logic                      tready_r;
  logic                      q_valid_r;
  logic [DEPTH*CHAR_LEN-1:0] q_data_r;
  logic                      err_r;

  logic                      accept_s;
  logic                      at_last_s;
  logic                      close_s;
  logic                      frame_err_s;
  logic                      free_s;
  bank_state_t               state_n_s [2];
  logic                      wr_bank_n_s;
  logic                      rd_bank_n_s;
  logic [CNT_W-1:0]          wr_cnt_n_s;
  logic                      tready_n_s;
  logic                      q_valid_n_s;
  logic [DEPTH*CHAR_LEN-1:0] q_data_n_s;

  // Next-state evaluation; every output register is loaded from these values.
  always_comb begin
    accept_s  = bus.s_axis_tvalid & tready_r;
    at_last_s = (wr_cnt_r == LAST_CNT);
`ifdef STREAM_IN_ERR_EN
    close_s     = accept_s & (at_last_s | bus.s_axis_tlast);
    frame_err_s = accept_s & (at_last_s ^ bus.s_axis_tlast);
`else
    close_s     = accept_s & at_last_s;
    frame_err_s = 1'b0;
`endif
    // Writes target a non-full bank and frees target a full one, so they never collide.
    free_s = bus.next & q_valid_r;

    for (int b = 0; b < 2; b++) begin
      if (free_s && (rd_bank_r == 1'(b))) begin
        state_n_s[b] = BANK_EMPTY;
      end else if (accept_s && (wr_bank_r == 1'(b))) begin
        state_n_s[b] = close_s ? BANK_FULL : BANK_FILLING;
      end else begin
        state_n_s[b] = state_r[b];
      end
    end

    wr_bank_n_s = wr_bank_r ^ close_s;
    rd_bank_n_s = rd_bank_r ^ free_s;

    if (close_s) begin
      wr_cnt_n_s = {CNT_W{1'b0}};
    end else if (accept_s) begin
      wr_cnt_n_s = wr_cnt_r + CNT_W'(1);
    end else begin
      wr_cnt_n_s = wr_cnt_r;
    end

    tready_n_s  = (state_n_s[wr_bank_n_s] != BANK_FULL);
    q_valid_n_s = (state_n_s[rd_bank_n_s] == BANK_FULL);

    // The beat landing this cycle is forwarded so a just-closed bank shows complete.
    q_data_n_s = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!q_valid_n_s) begin
        q_data_n_s[k*CHAR_LEN +: CHAR_LEN] = {CHAR_LEN{1'b0}};
      end else if (accept_s && (wr_bank_r == rd_bank_n_s) && (wr_cnt_r == CNT_W'(k))) begin
        q_data_n_s[k*CHAR_LEN +: CHAR_LEN] = bus.s_axis_tdata;
      end else begin
        q_data_n_s[k*CHAR_LEN +: CHAR_LEN] = bank_r[rd_bank_n_s][k];
      end
    end
  end

  // Bank storage, bank state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        state_r[b] <= BANK_EMPTY;
        for (int k = 0; k < DEPTH; k++) begin
          bank_r[b][k] <= {CHAR_LEN{1'b0}};
        end
      end
      wr_bank_r <= 1'b0;
      rd_bank_r <= 1'b0;
      wr_cnt_r  <= {CNT_W{1'b0}};
      tready_r  <= 1'b1;
      q_valid_r <= 1'b0;
      q_data_r  <= '0;
      err_r     <= 1'b0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        state_r[b] <= state_n_s[b];
        if (free_s && (rd_bank_r == 1'(b))) begin
          for (int k = 0; k < DEPTH; k++) begin
            bank_r[b][k] <= {CHAR_LEN{1'b0}};
          end
        end else if (accept_s && (wr_bank_r == 1'(b))) begin
          bank_r[b][wr_cnt_r] <= bus.s_axis_tdata;
        end else begin
          bank_r[b] <= bank_r[b];
        end
      end
      wr_bank_r <= wr_bank_n_s;
      rd_bank_r <= rd_bank_n_s;
      wr_cnt_r  <= wr_cnt_n_s;
      tready_r  <= tready_n_s;
      q_valid_r <= q_valid_n_s;
      q_data_r  <= q_data_n_s;
      err_r     <= err_r | frame_err_s;
    end
  end

  assign bus.s_axis_tready = tready_r;
  assign bus.q_valid       = q_valid_r;
  assign bus.q_data        = q_data_r;
  assign bus.err           = err_r;

endmodule

// File: tb/tb_stream_in_buf.sv
// Scoreboard bench for stream_in_buf: expected batches are queued at stimulus time and
// checked by a monitor whenever a new batch is presented on q_data.
module tb_stream_in_buf;
  localparam int CL    = 8;
  localparam int DEPTH = 40;
  localparam int W     = DEPTH * CL;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  logic [W-1:0] exp_q [$];

  always #5 clk = ~clk;

  stream_in_buf_if #(.CHAR_LEN(CL), .DEPTH(DEPTH)) bus ();

  stream_in_buf #(.CHAR_LEN(CL), .N(10), .BATCH_SIZE(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_vec(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] make_batch(input int base, input int len);
    logic [W-1:0] b;
    b = '0;
    for (int k = 0; k < DEPTH; k++) begin
      b[k*CL +: CL] = (k < len) ? 8'(base + k) : 8'h00;
    end
    return b;
  endfunction

  // Monitor: a batch is presented when q_valid rises or stays high after a taken next.
  logic prev_valid = 1'b0;
  logic next_pending = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_valid   = 1'b0;
      next_pending = 1'b0;
    end else begin
      if (bus.q_valid && (!prev_valid || next_pending)) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL batch: unexpected batch %h", bus.q_data);
        end else begin
          chk_vec("batch", bus.q_data, exp_q.pop_front());
        end
      end
      prev_valid   = bus.q_valid;
      next_pending = bus.next && bus.q_valid;
    end
  end

  // Called just after a rising edge; returns just after the edge that accepts the beat.
  task automatic send_beat(input logic [CL-1:0] d, input logic last);
    int n;
    bus.s_axis_tdata  = d;
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tlast  = last;
    n = 0;
    @(negedge clk);
    while (!bus.s_axis_tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL beat_wait: tready stayed 0, required 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
  endtask

  task automatic send_batch(input int base);
    for (int k = 0; k < DEPTH; k++) begin
      send_beat(8'(base + k), (k == DEPTH - 1));
    end
  endtask

  task automatic pulse_next();
    bus.next = 1'b1;
    @(posedge clk);
    #1;
    bus.next = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst               = 1'b1;
    bus.s_axis_tdata  = 8'h00;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    bus.next          = 1'b0;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    chk_bit("rst_tready", bus.s_axis_tready, 1'b1);
    chk_bit("rst_q_valid", bus.q_valid, 1'b0);
    chk_vec("rst_q_data", bus.q_data, '0);
    chk_bit("rst_err", bus.err, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: single batch, data=k
    exp_q.push_back(make_batch(0, DEPTH));
    send_batch(0);
    @(negedge clk);
    chk_bit("t1_q_valid", bus.q_valid, 1'b1);
    chk_bit("t1_err", bus.err, 1'b0);
    chk_bit("t1_tready", bus.s_axis_tready, 1'b1);
    @(posedge clk);
    #1;

    // 2: second batch fills bank1 without next, then next
    exp_q.push_back(make_batch(100, DEPTH));
    send_batch(100);
    @(negedge clk);
    chk_bit("t2_tready_full", bus.s_axis_tready, 1'b0);
    chk_vec("t2_q_data_held", bus.q_data, make_batch(0, DEPTH));
    @(posedge clk);
    #1;
    pulse_next();
    @(negedge clk);
    chk_bit("t2_q_valid", bus.q_valid, 1'b1);
    chk_bit("t2_beat0", bus.q_data[7:0] == 8'd100, 1'b1);
    chk_bit("t2_tready", bus.s_axis_tready, 1'b1);
    @(posedge clk);
    #1;

    // 3: both banks full, tvalid held 20 cycles
    exp_q.push_back(make_batch(200, DEPTH));
    send_batch(200);
    bus.s_axis_tdata  = 8'hAA;
    bus.s_axis_tvalid = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk_bit("t3_hold_tready", bus.s_axis_tready, 1'b0);
    end
    chk_vec("t3_q_data_stable", bus.q_data, make_batch(100, DEPTH));
    @(posedge clk);
    #1;
    bus.s_axis_tvalid = 1'b0;
    pulse_next();
    @(negedge clk);
    chk_bit("t3_one_free_valid", bus.q_valid, 1'b1);
    chk_bit("t3_one_free_tready", bus.s_axis_tready, 1'b1);
    @(posedge clk);
    #1;

    // 4: next on the same edge as the last beat of bank1
    exp_q.push_back(make_batch(50, DEPTH));
    for (int k = 0; k < DEPTH - 1; k++) begin
      send_beat(8'(50 + k), 1'b0);
    end
    bus.s_axis_tdata  = 8'(50 + DEPTH - 1);
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tlast  = 1'b1;
    bus.next          = 1'b1;
    @(negedge clk);
    chk_bit("t4_pre_tready", bus.s_axis_tready, 1'b1);
    @(posedge clk);
    #1;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    bus.next          = 1'b0;
    @(negedge clk);
    chk_bit("t4_q_valid", bus.q_valid, 1'b1);
    chk_bit("t4_tready", bus.s_axis_tready, 1'b1);
    @(posedge clk);
    #1;
    pulse_next();
    @(negedge clk);
    chk_bit("t4_drain_valid", bus.q_valid, 1'b0);
    chk_vec("t4_drain_zero", bus.q_data, '0);
    @(posedge clk);
    #1;

    // 5: TLAST at beat 5 of 40
`ifdef STREAM_IN_ERR_EN
    exp_q.push_back(make_batch(1, 6));
`endif
    for (int k = 0; k < 6; k++) begin
      send_beat(8'(1 + k), (k == 5));
    end
    @(negedge clk);
`ifdef STREAM_IN_ERR_EN
    chk_bit("t5_q_valid", bus.q_valid, 1'b1);
    chk_bit("t5_err", bus.err, 1'b1);
`else
    chk_bit("t5_q_valid", bus.q_valid, 1'b0);
    chk_bit("t5_err", bus.err, 1'b0);
    chk_bit("t5_tready", bus.s_axis_tready, 1'b1);
`endif
    @(posedge clk);
    #1;

    // 6: reset mid-fill, then a clean batch from beat 0
    do_reset();
    for (int k = 0; k < 17; k++) begin
      send_beat(8'(30 + k), 1'b0);
    end
    do_reset();
    @(negedge clk);
    chk_bit("t6_q_valid", bus.q_valid, 1'b0);
    chk_bit("t6_tready", bus.s_axis_tready, 1'b1);
    chk_bit("t6_err", bus.err, 1'b0);
    chk_vec("t6_q_data", bus.q_data, '0);
    @(posedge clk);
    #1;
    exp_q.push_back(make_batch(3, DEPTH));
    send_batch(3);
    @(negedge clk);
    chk_bit("t6_after_valid", bus.q_valid, 1'b1);
    chk_bit("t6_after_err", bus.err, 1'b0);
    repeat (3) @(negedge clk);

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d batches left, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
